pim_trace: RTL and testbench

Parametrised PIM debug capture block for the NPI interconnect, monitoring one PIM port. It registers all PIM handshake and data signals onto a live debug bus for ChipScope and records PIM events (address acceptance, protocol errors, FIFO flushes) with timestamps into a circular trace RAM. Software or JTAG reads the RAM after a trigger freezes it.

---
 rtl/pim_trace_pkg.sv | 41 ++++
 rtl/pim_trace_if.sv | 41 ++++
 rtl/pim_trace_ram.sv | 32 +++
 rtl/pim_trace.sv | 179 +++++++++++++++++
 tb/tb_pim_trace.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pim_trace_pkg.sv
// Shared definitions for the PIM trace block: FSM states, trace entry type
// codes, PIM_dbg bit offsets and the entry packing helper.
package pim_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_POST   = 2'd2,
    ST_FROZEN = 2'd3
  } state_e;

  localparam logic [1:0] TYPE_CMD   = 2'b01;
  localparam logic [1:0] TYPE_ERR   = 2'b10;
  localparam logic [1:0] TYPE_FLUSH = 2'b11;

  localparam int DBG_ADDR    = 0;
  localparam int DBG_ACK     = 32;
  localparam int DBG_INIT    = 33;
  localparam int DBG_RNW     = 34;
  localparam int DBG_RDEMPTY = 35;
  localparam int DBG_RDFLUSH = 36;
  localparam int DBG_LAT     = 37;
  localparam int DBG_POP     = 39;
  localparam int DBG_RDWD    = 40;
  localparam int DBG_RMW     = 44;
  localparam int DBG_SIZE    = 45;
  localparam int DBG_AF      = 49;
  localparam int DBG_WREMPTY = 50;
  localparam int DBG_WRFLUSH = 51;
  localparam int DBG_BE      = 52;
  localparam int DBG_REQ     = 60;
  localparam int DBG_PUSH    = 61;
  localparam int DBG_RDDATA  = 64;

  // Entry layout: [63:62] type, [61:46] timestamp, [45:0] payload.
  function automatic logic [63:0] pack_entry(logic [1:0] typ, logic [15:0] ts,
                                             logic [45:0] payload);
    return {typ, ts, payload};
  endfunction

endpackage

// File: rtl/pim_trace_if.sv
// PIM port signal bundle. The master side drives the PIM, the slave side is
// the passive monitor used by the trace block.
interface pim_trace_if #(
  parameter int C_DATA_WIDTH = 64
);
  logic [31:0]               PIM_Addr;
  logic                      PIM_AddrReq;
  logic                      PIM_AddrAck;
  logic                      PIM_InitDone;
  logic                      PIM_RNW;
  logic                      PIM_RdModWr;
  logic [3:0]                PIM_Size;
  logic [C_DATA_WIDTH-1:0]   PIM_RdFIFO_Data;
  logic                      PIM_RdFIFO_Empty;
  logic                      PIM_RdFIFO_Flush;
  logic                      PIM_RdFIFO_Pop;
  logic [1:0]                PIM_RdFIFO_Latency;
  logic [3:0]                PIM_RdFIFO_RdWdAddr;
  logic [C_DATA_WIDTH-1:0]   PIM_WrFIFO_Data;
  logic [C_DATA_WIDTH/8-1:0] PIM_WrFIFO_BE;
  logic                      PIM_WrFIFO_Empty;
  logic                      PIM_WrFIFO_AlmostFull;
  logic                      PIM_WrFIFO_Flush;
  logic                      PIM_WrFIFO_Push;

  modport master (
    output PIM_Addr, PIM_AddrReq, PIM_AddrAck, PIM_InitDone, PIM_RNW, PIM_RdModWr,
           PIM_Size, PIM_RdFIFO_Data, PIM_RdFIFO_Empty, PIM_RdFIFO_Flush,
           PIM_RdFIFO_Pop, PIM_RdFIFO_Latency, PIM_RdFIFO_RdWdAddr,
           PIM_WrFIFO_Data, PIM_WrFIFO_BE, PIM_WrFIFO_Empty,
           PIM_WrFIFO_AlmostFull, PIM_WrFIFO_Flush, PIM_WrFIFO_Push
  );

  modport slave (
    input  PIM_Addr, PIM_AddrReq, PIM_AddrAck, PIM_InitDone, PIM_RNW, PIM_RdModWr,
           PIM_Size, PIM_RdFIFO_Data, PIM_RdFIFO_Empty, PIM_RdFIFO_Flush,
           PIM_RdFIFO_Pop, PIM_RdFIFO_Latency, PIM_RdFIFO_RdWdAddr,
           PIM_WrFIFO_Data, PIM_WrFIFO_BE, PIM_WrFIFO_Empty,
           PIM_WrFIFO_AlmostFull, PIM_WrFIFO_Flush, PIM_WrFIFO_Push
  );
endinterface

// File: rtl/pim_trace_ram.sv
// Simple dual-port trace RAM with a registered read port. A read of the slot
// being written in the same cycle returns the previous contents.
module pim_trace_ram #(
  parameter int AW = 9,
  parameter int DW = 64
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  // Write port; array contents are intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Registered read port, output register cleared by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rdata_q <= '0;
    else       rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pim_trace.sv
// PIM debug capture: registered live debug bus plus an event trace that
// records CMD/ERR/FLUSH events with timestamps into a circular RAM and
// freezes a programmable number of entries after a trigger.
module pim_trace
  import pim_trace_pkg::*;
#(
  parameter int C_DATA_WIDTH  = 64,
  parameter int C_DEPTH_LOG2  = 9,
  parameter int C_TS_WIDTH    = 16,
  parameter int C_POST_TRIG   = 256,
  parameter int C_TRIG_ON_ERR = 1
) (
  input  logic                         MPMC_Clk,
  input  logic                         MPMC_Rst,
  pim_trace_if.slave                   pim,
  input  logic                         Trig_In,
  input  logic                         Arm,
  input  logic [C_DEPTH_LOG2-1:0]      Rd_Addr,
  output logic [63:0]                  Rd_Data,
  output logic [64+2*C_DATA_WIDTH-1:0] PIM_dbg,
  output logic [1:0]                   Status,
  output logic [C_DEPTH_LOG2-1:0]      Wr_Ptr,
  output logic [C_DEPTH_LOG2-1:0]      Trig_Ptr,
  output logic                         Wrapped,
  output logic [7:0]                   Drop_Cnt
);

  localparam int BEW   = C_DATA_WIDTH / 8;
  localparam int DBG_W = 64 + 2 * C_DATA_WIDTH;
  // One spare bit so the post counter can always hold C_POST_TRIG.
  localparam int PW    = C_DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] POST_LIM = PW'(C_POST_TRIG);

  state_e                  state_q;
  logic [C_DEPTH_LOG2-1:0] wr_ptr_q, trig_ptr_q;
  logic                    wrapped_q;
  logic [7:0]              drop_q;
  logic [PW-1:0]           post_q;
  logic [C_TS_WIDTH-1:0]   ts_q;
  logic [DBG_W-1:0]        dbg_q, dbg_d;

  logic        ev_cmd, ev_pop_empty, ev_push_full, ev_err, ev_flush;
  logic        can_wr, wr_en_d, trig_d;
  logic [1:0]  drops_d;
  logic [63:0] entry_d;
  logic [15:0] ts_ext;
  logic [8:0]  drop_sum;
  logic [PW-1:0] post_inc;

  assign ev_cmd       = pim.PIM_AddrReq & pim.PIM_AddrAck;
  assign ev_pop_empty = pim.PIM_RdFIFO_Pop & pim.PIM_RdFIFO_Empty;
  assign ev_push_full = pim.PIM_WrFIFO_Push & ~pim.PIM_WrFIFO_Empty &
                        pim.PIM_WrFIFO_AlmostFull;
  assign ev_err       = ev_pop_empty | ev_push_full;
  assign ev_flush     = pim.PIM_RdFIFO_Flush | pim.PIM_WrFIFO_Flush;
  assign trig_d       = Trig_In | ((C_TRIG_ON_ERR != 0) & ev_err);
  assign can_wr       = ((state_q == ST_ARMED) || (state_q == ST_POST)) && !Arm;
  assign drop_sum     = {1'b0, drop_q} + {7'd0, drops_d};
  assign post_inc     = post_q + 1'b1;

  // Debug bus assembly from the raw PIM inputs.
  always_comb begin
    dbg_d = '0;
    dbg_d[DBG_ADDR +: 32]     = pim.PIM_Addr;
    dbg_d[DBG_ACK]            = pim.PIM_AddrAck;
    dbg_d[DBG_INIT]           = pim.PIM_InitDone;
    dbg_d[DBG_RNW]            = pim.PIM_RNW;
    dbg_d[DBG_RDEMPTY]        = pim.PIM_RdFIFO_Empty;
    dbg_d[DBG_RDFLUSH]        = pim.PIM_RdFIFO_Flush;
    dbg_d[DBG_LAT +: 2]       = pim.PIM_RdFIFO_Latency;
    dbg_d[DBG_POP]            = pim.PIM_RdFIFO_Pop;
    dbg_d[DBG_RDWD +: 4]      = pim.PIM_RdFIFO_RdWdAddr;
    dbg_d[DBG_RMW]            = pim.PIM_RdModWr;
    dbg_d[DBG_SIZE +: 4]      = pim.PIM_Size;
    dbg_d[DBG_AF]             = pim.PIM_WrFIFO_AlmostFull;
    dbg_d[DBG_WREMPTY]        = pim.PIM_WrFIFO_Empty;
    dbg_d[DBG_WRFLUSH]        = pim.PIM_WrFIFO_Flush;
    dbg_d[DBG_BE +: BEW]      = pim.PIM_WrFIFO_BE;
    dbg_d[DBG_REQ]            = pim.PIM_AddrReq;
    dbg_d[DBG_PUSH]           = pim.PIM_WrFIFO_Push;
    dbg_d[DBG_RDDATA +: C_DATA_WIDTH]                = pim.PIM_RdFIFO_Data;
    dbg_d[DBG_RDDATA + C_DATA_WIDTH +: C_DATA_WIDTH] = pim.PIM_WrFIFO_Data;
  end

  // Event arbitration: pick the highest-priority event and count the rest as drops.
  always_comb begin
    ts_ext = '0;
    ts_ext[C_TS_WIDTH-1:0] = ts_q;
    entry_d = '0;
    drops_d = '0;
    if (ev_cmd) begin
      entry_d = pack_entry(TYPE_CMD, ts_ext,
                           {8'd0, pim.PIM_RdModWr, pim.PIM_RNW, pim.PIM_Size, pim.PIM_Addr});
      drops_d = {1'b0, ev_err} + {1'b0, ev_flush};
    end else if (ev_err) begin
      entry_d = pack_entry(TYPE_ERR, ts_ext, {44'd0, ev_push_full, ev_pop_empty});
      drops_d = {1'b0, ev_flush};
    end else if (ev_flush) begin
      entry_d = pack_entry(TYPE_FLUSH, ts_ext,
                           {44'd0, pim.PIM_WrFIFO_Flush, pim.PIM_RdFIFO_Flush});
    end
    wr_en_d = can_wr && (ev_cmd || ev_err || ev_flush);
    if (!can_wr) drops_d = '0;
  end

  // Free-running timestamp, cleared only by reset.
  always_ff @(posedge MPMC_Clk or posedge MPMC_Rst) begin
    if (MPMC_Rst) ts_q <= '0;
    else          ts_q <= ts_q + 1'b1;
  end

  // Live debug bus register.
  always_ff @(posedge MPMC_Clk or posedge MPMC_Rst) begin
    if (MPMC_Rst) dbg_q <= '0;
    else          dbg_q <= dbg_d;
  end

  // Capture FSM with write pointer, wrap flag, drop counter and post counter.
  always_ff @(posedge MPMC_Clk or posedge MPMC_Rst) begin
    if (MPMC_Rst) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      trig_ptr_q <= '0;
      wrapped_q  <= 1'b0;
      drop_q     <= '0;
      post_q     <= '0;
    end else if (Arm) begin
      state_q    <= ST_ARMED;
      wr_ptr_q   <= '0;
      trig_ptr_q <= '0;
      wrapped_q  <= 1'b0;
      drop_q     <= '0;
      post_q     <= '0;
    end else begin
      if (wr_en_d) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        if (wr_ptr_q == '1) wrapped_q <= 1'b1;
      end
      drop_q <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      case (state_q)
        ST_ARMED: begin
          if (trig_d) begin
            trig_ptr_q <= wr_ptr_q;
            post_q     <= '0;
            state_q    <= (C_POST_TRIG == 0) ? ST_FROZEN : ST_POST;
          end
        end
        ST_POST: begin
          if (wr_en_d) begin
            post_q <= post_inc;
            if (post_inc == POST_LIM) state_q <= ST_FROZEN;
          end
        end
        default: ;
      endcase
    end
  end

  pim_trace_ram #(
    .AW (C_DEPTH_LOG2),
    .DW (64)
  ) u_ram (
    .clk_i   (MPMC_Clk),
    .rst_i   (MPMC_Rst),
    .we_i    (wr_en_d),
    .waddr_i (wr_ptr_q),
    .wdata_i (entry_d),
    .raddr_i (Rd_Addr),
    .rdata_o (Rd_Data)
  );

  assign PIM_dbg  = dbg_q;
  assign Status   = state_q;
  assign Wr_Ptr   = wr_ptr_q;
  assign Trig_Ptr = trig_ptr_q;
  assign Wrapped  = wrapped_q;
  assign Drop_Cnt = drop_q;

endmodule

// File: tb/tb_pim_trace.sv
// Self-checking bench for pim_trace: directed scenarios followed by random
// traffic, all compared against a behavioural model of the trace rules.
module tb_pim_trace;

  localparam int DW    = 64;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int POST  = 4;

  logic           MPMC_Clk = 1'b0;
  logic           MPMC_Rst;
  logic           Trig_In, Arm;
  logic [AW-1:0]  Rd_Addr;
  logic [63:0]    Rd_Data;
  logic [64+2*DW-1:0] PIM_dbg;
  logic [1:0]     Status;
  logic [AW-1:0]  Wr_Ptr, Trig_Ptr;
  logic           Wrapped;
  logic [7:0]     Drop_Cnt;

  pim_trace_if #(.C_DATA_WIDTH(DW)) pif ();

  pim_trace #(
    .C_DATA_WIDTH (DW),
    .C_DEPTH_LOG2 (AW),
    .C_TS_WIDTH   (16),
    .C_POST_TRIG  (POST),
    .C_TRIG_ON_ERR(1)
  ) dut (
    .MPMC_Clk (MPMC_Clk),
    .MPMC_Rst (MPMC_Rst),
    .pim      (pif.slave),
    .Trig_In  (Trig_In),
    .Arm      (Arm),
    .Rd_Addr  (Rd_Addr),
    .Rd_Data  (Rd_Data),
    .PIM_dbg  (PIM_dbg),
    .Status   (Status),
    .Wr_Ptr   (Wr_Ptr),
    .Trig_Ptr (Trig_Ptr),
    .Wrapped  (Wrapped),
    .Drop_Cnt (Drop_Cnt)
  );

  always #5 MPMC_Clk = ~MPMC_Clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioural model state.
  int          m_st, m_wp, m_trig, m_post, m_drop;
  bit          m_wrap;
  logic [15:0] m_ts;
  logic [63:0] m_mem [DEPTH];
  bit          m_val [DEPTH];

  task automatic model_reset();
    m_st = 0; m_wp = 0; m_trig = 0; m_post = 0; m_drop = 0; m_wrap = 0; m_ts = '0;
  endtask

  task automatic set_idle();
    pif.PIM_Addr = '0; pif.PIM_AddrReq = 0; pif.PIM_AddrAck = 0; pif.PIM_InitDone = 1;
    pif.PIM_RNW = 0; pif.PIM_RdModWr = 0; pif.PIM_Size = '0; pif.PIM_RdFIFO_Data = '0;
    pif.PIM_RdFIFO_Empty = 1; pif.PIM_RdFIFO_Flush = 0; pif.PIM_RdFIFO_Pop = 0;
    pif.PIM_RdFIFO_Latency = '0; pif.PIM_RdFIFO_RdWdAddr = '0; pif.PIM_WrFIFO_Data = '0;
    pif.PIM_WrFIFO_BE = '0; pif.PIM_WrFIFO_Empty = 1; pif.PIM_WrFIFO_AlmostFull = 0;
    pif.PIM_WrFIFO_Flush = 0; pif.PIM_WrFIFO_Push = 0;
    Trig_In = 0; Arm = 0;
  endtask

  task automatic set_random();
    pif.PIM_Addr = $urandom; pif.PIM_AddrReq = 1'($urandom); pif.PIM_AddrAck = 1'($urandom);
    pif.PIM_InitDone = 1'($urandom); pif.PIM_RNW = 1'($urandom); pif.PIM_RdModWr = 1'($urandom);
    pif.PIM_Size = 4'($urandom); pif.PIM_RdFIFO_Data = {$urandom, $urandom};
    pif.PIM_RdFIFO_Empty = 1'($urandom); pif.PIM_RdFIFO_Flush = ($urandom_range(0, 7) == 0);
    pif.PIM_RdFIFO_Pop = ($urandom_range(0, 3) == 0); pif.PIM_RdFIFO_Latency = 2'($urandom);
    pif.PIM_RdFIFO_RdWdAddr = 4'($urandom); pif.PIM_WrFIFO_Data = {$urandom, $urandom};
    pif.PIM_WrFIFO_BE = 8'($urandom); pif.PIM_WrFIFO_Empty = 1'($urandom);
    pif.PIM_WrFIFO_AlmostFull = 1'($urandom); pif.PIM_WrFIFO_Flush = ($urandom_range(0, 7) == 0);
    pif.PIM_WrFIFO_Push = ($urandom_range(0, 3) == 0);
    Trig_In = ($urandom_range(0, 15) == 0); Arm = ($urandom_range(0, 40) == 0);
    Rd_Addr = 4'($urandom);
  endtask

  // One clock: predict from current inputs, advance, compare every output.
  task automatic cycle();
    logic cmd, pe, pf, err, fl, wr;
    int nev, old_wp;
    logic [63:0] rd_exp, ent;
    bit rd_known;
    logic [191:0] dbg_exp;
    cmd = pif.PIM_AddrReq & pif.PIM_AddrAck;
    pe  = pif.PIM_RdFIFO_Pop & pif.PIM_RdFIFO_Empty;
    pf  = pif.PIM_WrFIFO_Push & ~pif.PIM_WrFIFO_Empty & pif.PIM_WrFIFO_AlmostFull;
    err = pe | pf;
    fl  = pif.PIM_RdFIFO_Flush | pif.PIM_WrFIFO_Flush;
    nev = int'(cmd) + int'(err) + int'(fl);
    rd_known = m_val[Rd_Addr];
    rd_exp   = m_mem[Rd_Addr];
    dbg_exp = {pif.PIM_WrFIFO_Data, pif.PIM_RdFIFO_Data, 2'b00, pif.PIM_WrFIFO_Push,
               pif.PIM_AddrReq, pif.PIM_WrFIFO_BE, pif.PIM_WrFIFO_Flush, pif.PIM_WrFIFO_Empty,
               pif.PIM_WrFIFO_AlmostFull, pif.PIM_Size, pif.PIM_RdModWr, pif.PIM_RdFIFO_RdWdAddr,
               pif.PIM_RdFIFO_Pop, pif.PIM_RdFIFO_Latency, pif.PIM_RdFIFO_Flush,
               pif.PIM_RdFIFO_Empty, pif.PIM_RNW, pif.PIM_InitDone, pif.PIM_AddrAck, pif.PIM_Addr};
    if (Arm) begin
      m_st = 1; m_wp = 0; m_wrap = 0; m_drop = 0; m_trig = 0; m_post = 0;
    end else begin
      wr = (m_st == 1 || m_st == 2) && nev > 0;
      old_wp = m_wp;
      if (wr) begin
        if (cmd)
          ent = {2'b01, m_ts, 8'd0, pif.PIM_RdModWr, pif.PIM_RNW, pif.PIM_Size, pif.PIM_Addr};
        else if (err)
          ent = {2'b10, m_ts, 44'd0, pf, pe};
        else
          ent = {2'b11, m_ts, 44'd0, pif.PIM_WrFIFO_Flush, pif.PIM_RdFIFO_Flush};
        m_mem[m_wp] = ent;
        m_val[m_wp] = 1;
        m_drop = (m_drop + nev - 1 > 255) ? 255 : m_drop + nev - 1;
        if (m_wp == DEPTH - 1) m_wrap = 1;
        m_wp = (m_wp + 1) % DEPTH;
      end
      if (m_st == 1 && (Trig_In || err)) begin
        m_trig = old_wp; m_post = 0; m_st = (POST == 0) ? 3 : 2;
      end else if (m_st == 2 && wr) begin
        m_post++;
        if (m_post == POST) m_st = 3;
      end
    end
    m_ts = m_ts + 16'd1;
    @(posedge MPMC_Clk);
    #1;
    chk("status",   192'(Status),   192'(m_st));
    chk("wr_ptr",   192'(Wr_Ptr),   192'(m_wp));
    chk("trig_ptr", 192'(Trig_Ptr), 192'(m_trig));
    chk("wrapped",  192'(Wrapped),  192'(m_wrap));
    chk("drop_cnt", 192'(Drop_Cnt), 192'(m_drop));
    chk("pim_dbg",  192'(PIM_dbg),  dbg_exp);
    if (rd_known) chk("rd_data", 192'(Rd_Data), 192'(rd_exp));
  endtask

  task automatic do_reset();
    MPMC_Rst = 1;
    #1;
    model_reset();
    chk("rst_status",  192'(Status),   192'(0));
    chk("rst_wr_ptr",  192'(Wr_Ptr),   192'(0));
    chk("rst_trig",    192'(Trig_Ptr), 192'(0));
    chk("rst_wrapped", 192'(Wrapped),  192'(0));
    chk("rst_drop",    192'(Drop_Cnt), 192'(0));
    chk("rst_dbg",     192'(PIM_dbg),  192'(0));
    chk("rst_rd_data", 192'(Rd_Data),  192'(0));
    @(posedge MPMC_Clk);
    #1;
    MPMC_Rst = 0;
  endtask

  task automatic do_cmd(input logic [31:0] addr, input logic [3:0] size, input logic rnw);
    set_idle();
    pif.PIM_AddrReq = 1; pif.PIM_AddrAck = 1;
    pif.PIM_Addr = addr; pif.PIM_Size = size; pif.PIM_RNW = rnw;
    cycle();
  endtask

  task automatic do_arm();
    set_idle(); Arm = 1; cycle(); set_idle();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_val[i] = 0;
    MPMC_Rst = 1;
    Rd_Addr = '0;
    set_idle();
    #2;
    do_reset();

    // Arm, then a single CMD into slot 0.
    do_arm();
    chk("armed_status", 192'(Status), 192'(1));
    do_cmd(32'h1000_0040, 4'd3, 1'b1);
    chk("cmd_wp", 192'(Wr_Ptr), 192'(1));
    set_idle(); Rd_Addr = '0; cycle();
    chk("cmd_type",    192'(Rd_Data[63:62]), 192'(2'b01));
    chk("cmd_payload", 192'(Rd_Data[45:0]),  192'(46'h13_1000_0040));

    // CMD and FLUSH together: one CMD entry, one drop.
    set_idle();
    pif.PIM_AddrReq = 1; pif.PIM_AddrAck = 1; pif.PIM_Addr = 32'h2222_0000;
    pif.PIM_WrFIFO_Flush = 1;
    cycle();
    chk("collide_drop", 192'(Drop_Cnt), 192'(1));
    chk("collide_wp",   192'(Wr_Ptr),   192'(2));
    set_idle(); Rd_Addr = 4'd1; cycle();
    chk("collide_type", 192'(Rd_Data[63:62]), 192'(2'b01));

    // Wrap: 17 CMDs into a 16-slot RAM.
    do_arm();
    for (int i = 0; i < 17; i++) do_cmd(32'hA000_0000 + 32'(i), 4'd1, 1'b0);
    chk("wrap_flag", 192'(Wrapped), 192'(1));
    chk("wrap_wp",   192'(Wr_Ptr),  192'(1));
    set_idle(); Rd_Addr = '0; cycle();
    chk("wrap_slot0", 192'(Rd_Data[31:0]), 192'(32'hA000_0010));

    // Post-trigger: trigger at slot 5 with an entry, freeze after slot 9.
    do_arm();
    for (int i = 0; i < 5; i++) do_cmd(32'hB000_0000 + 32'(i), 4'd2, 1'b1);
    set_idle();
    pif.PIM_AddrReq = 1; pif.PIM_AddrAck = 1; pif.PIM_Addr = 32'hB000_0005; Trig_In = 1;
    cycle();
    chk("post_status", 192'(Status), 192'(2));
    for (int i = 0; i < 10; i++) do_cmd(32'hC000_0000 + 32'(i), 4'd4, 1'b0);
    chk("post_trig_ptr", 192'(Trig_Ptr), 192'(5));
    chk("post_frozen",   192'(Status),   192'(3));
    chk("post_wp",       192'(Wr_Ptr),   192'(10));

    // ERR trigger from a pop on an empty read FIFO.
    do_arm();
    set_idle(); pif.PIM_RdFIFO_Pop = 1; pif.PIM_RdFIFO_Empty = 1; cycle();
    chk("err_status", 192'(Status), 192'(2));
    set_idle(); Rd_Addr = '0; cycle();
    chk("err_type",    192'(Rd_Data[63:62]), 192'(2'b10));
    chk("err_payload", 192'(Rd_Data[1:0]),   192'(2'b01));

    // Reset during POST aborts capture; later CMD not recorded until Arm.
    set_idle();
    do_reset();
    do_cmd(32'hD000_0000, 4'd1, 1'b0);
    chk("post_rst_wp",     192'(Wr_Ptr), 192'(0));
    chk("post_rst_status", 192'(Status), 192'(0));

    // Random traffic against the model.
    do_arm();
    for (int i = 0; i < 1500; i++) begin
      set_random();
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
